// File: rtl/sram_seq_pkg.sv
// Shared types and constants for the external SRAM access sequencer.
// Pin idle levels live here so every state that parks the bus agrees on them.
package sram_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  localparam int HW_PER_BLOCK = 4;
  localparam int HW_PER_WORD  = 2;

  localparam logic CE_N_IDLE  = 1'b1;
  localparam logic WE_N_IDLE  = 1'b1;
  localparam logic OE_N_IDLE  = 1'b1;
  localparam logic DQ_OE_IDLE = 1'b0;

endpackage

// File: rtl/sram_access_sequencer_counter.sv
// Nested wait/halfword counter: wait runs 0..WAIT_CYCLES per halfword, halfword runs 0..hw_last_i.
// Both clear whenever en_i is low, so every access starts from zero.
module sram_seq_counter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] hw_last_i,
  output logic [1:0] hw_cnt_o,
  output logic       hw_end_o,
  output logic       last_o
);

  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

  logic [2:0] wait_q, wait_d;
  logic [1:0] hw_q, hw_d;

  assign hw_end_o = en_i && (wait_q == WAIT_LAST);
  assign last_o   = hw_end_o && (hw_q == hw_last_i);
  assign hw_cnt_o = hw_q;

  always_comb begin
    wait_d = wait_q;
    hw_d   = hw_q;
    if (!en_i) begin
      wait_d = '0;
      hw_d   = '0;
    end else if (hw_end_o) begin
      wait_d = '0;
      hw_d   = last_o ? 2'd0 : hw_q + 2'd1;
    end else begin
      wait_d = wait_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
      hw_q   <= '0;
    end else begin
      wait_q <= wait_d;
      hw_q   <= hw_d;
    end
  end

endmodule

// File: rtl/sram_access_sequencer.sv
// Drives the async 16-bit SRAM for the cache: 64-bit block reads as 4 halfwords, 32-bit writes as 2.
// Pins decode from registered state only, so address/data hold steady across each halfword.
module sram_access_sequencer
  import sram_seq_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int SRAM_ADDR_W = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            addr_in,
  input  logic [31:0]            wdata_in,
  input  logic                   r_en_in,
  input  logic                   w_en_in,
  output logic [63:0]            rdata_out,
  output logic                   ready_out,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_we_n,
  output logic                   sram_oe_n,
  output logic                   sram_ce_n,
  output logic                   sram_ub_n,
  output logic                   sram_lb_n
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [16:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;

  logic        access;
  logic        hw_end;
  logic        last;
  logic [1:0]  hw_cnt;
  logic [1:0]  hw_last;
  logic [17:0] hw_addr;
  logic        unused_addr;

  // Only the low 17 word-address bits reach an 18-bit halfword address.
  assign unused_addr = ^addr_in[31:17];

  assign access  = (state_q == ACCESS);
  assign hw_last = (op_q == OP_READ) ? 2'(HW_PER_BLOCK - 1) : 2'(HW_PER_WORD - 1);

  sram_seq_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .en_i     (access),
    .hw_last_i(hw_last),
    .hw_cnt_o (hw_cnt),
    .hw_end_o (hw_end),
    .last_o   (last)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (w_en_in || r_en_in) begin
          state_d = ACCESS;
          op_d    = w_en_in ? OP_WRITE : OP_READ;
          addr_d  = addr_in[16:0];
          wdata_d = wdata_in;
        end
      end
      ACCESS: begin
        // Sample the pad on the final cycle of each read halfword.
        if (op_q == OP_READ && hw_end) begin
          rdata_d[{hw_cnt, 4'b0000} +: 16] = sram_dq_in;
        end
        if (last) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign hw_addr = (op_q == OP_READ) ? {addr_q[16:1], hw_cnt} : {addr_q, hw_cnt[0]};

  always_comb begin
    sram_ce_n   = CE_N_IDLE;
    sram_we_n   = WE_N_IDLE;
    sram_oe_n   = OE_N_IDLE;
    sram_dq_oe  = DQ_OE_IDLE;
    sram_addr   = '0;
    sram_dq_out = 16'h0000;
    if (access) begin
      sram_ce_n = 1'b0;
      sram_addr = SRAM_ADDR_W'(hw_addr);
      if (op_q == OP_WRITE) begin
        sram_we_n   = 1'b0;
        sram_dq_oe  = 1'b1;
        sram_dq_out = hw_cnt[0] ? wdata_q[31:16] : wdata_q[15:0];
      end else begin
        sram_oe_n = 1'b0;
      end
    end
  end

  assign ready_out = (state_q == DONE);
  assign rdata_out = rdata_q;
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;

endmodule
